// File: rtl/ultrasonic_sensor_frontend_pkg.sv
// Shared types and default timing for the three-channel ultrasonic ranging front end.
package ultrasonic_sensor_frontend_pkg;

  localparam int NUM_CH = 3;

  // Defaults assume a 10 MHz clk
  localparam int unsigned DEF_TRIG_CYCLES    = 100;
  localparam int unsigned DEF_NEAR_CYCLES    = 58000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 300000;
  localparam int unsigned DEF_GAP_CYCLES     = 100000;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_e;

endpackage

// File: rtl/ultrasonic_sensor_frontend_if.sv
// Measurement result bus: per-channel near flags plus an update strobe and its channel.
interface ultrasonic_sensor_frontend_if;
  import ultrasonic_sensor_frontend_pkg::*;

  logic [NUM_CH-1:0] near;
  logic              meas_valid;
  logic [1:0]        meas_chan;

  modport master (output near, meas_valid, meas_chan);
  modport slave  (input  near, meas_valid, meas_chan);
endinterface

// File: rtl/ultrasonic_sensor_frontend_echo_sync.sv
// One echo lane: 2-flop synchronizer plus history flop for edge detection.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~hist;
  assign fall  = ~s2 & hist;

endmodule

// File: rtl/ultrasonic_sensor_frontend.sv
// Round-robin trigger/echo timer for three ultrasonic sensors; flags echoes shorter than NEAR_CYCLES.
module ultrasonic_sensor_frontend
  import ultrasonic_sensor_frontend_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned NEAR_CYCLES    = DEF_NEAR_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [NUM_CH-1:0]            echo_in,
  output logic [NUM_CH-1:0]            trig_out,
  ultrasonic_sensor_frontend_if.master meas
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state, state_d;
  logic [CW-1:0]     cnt;
  logic [31:0]       cnt32;
  logic [1:0]        ch, ch_d;
  logic              upd, near_val, cnt_en;
  logic [NUM_CH-1:0] echo_s, echo_rise, echo_fall;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    echo_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (echo_in[i]),
      .level (echo_s[i]),
      .rise  (echo_rise[i]),
      .fall  (echo_fall[i])
    );
  end

  assign cnt32 = 32'(cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    ch_d     = ch;
    upd      = 1'b0;
    near_val = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      IDLE: state_d = TRIG;
      TRIG: begin
        cnt_en = 1'b1;
        if (cnt32 == TRIG_CYCLES - 1) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        cnt_en = 1'b1;
        if (echo_rise[ch]) state_d = MEASURE;
        else if (cnt32 == TIMEOUT_CYCLES - 1) begin
          upd     = 1'b1;
          state_d = GAP;
        end
      end
      MEASURE: begin
        cnt_en = echo_s[ch];
        if (echo_fall[ch]) begin
          // The rise cycle that entered MEASURE is not in cnt, so width = cnt+1
          upd      = 1'b1;
          near_val = (cnt32 < NEAR_CYCLES - 1);
          state_d  = GAP;
        end else if (cnt32 == TIMEOUT_CYCLES - 1) begin
          upd     = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_en = 1'b1;
        if (cnt32 == GAP_CYCLES - 1) begin
          ch_d    = (ch == 2'd2) ? 2'd0 : ch + 2'd1;
          state_d = ena ? TRIG : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!ena) begin
      state_d = IDLE;
      ch_d    = 2'd0;
      upd     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt             <= '0;
      ch              <= 2'd0;
      trig_out        <= '0;
      meas.near       <= '0;
      meas.meas_valid <= 1'b0;
      meas.meas_chan  <= 2'd0;
    end else begin
      if (state_d != state) cnt <= '0;
      else if (cnt_en)      cnt <= cnt + CW'(1);
      ch              <= ch_d;
      trig_out        <= (state_d == TRIG) ? (NUM_CH'(1) << ch_d) : '0;
      meas.meas_valid <= upd;
      if (upd) begin
        meas.near[ch]  <= near_val;
        meas.meas_chan <= ch;
      end
      if (!ena) meas.near <= '0;
    end
  end

endmodule

// File: tb/tb_ultrasonic_sensor_frontend.sv
// Directed bench for the ultrasonic front end with shortened timing parameters.
module tb_ultrasonic_sensor_frontend;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] echo_in = 3'b000;
  logic [2:0] trig_out;
  int         errors = 0;
  int         checks = 0;

  ultrasonic_sensor_frontend_if mif ();

  ultrasonic_sensor_frontend #(
    .TRIG_CYCLES    (4),
    .NEAR_CYCLES    (50),
    .TIMEOUT_CYCLES (200),
    .GAP_CYCLES     (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .echo_in  (echo_in),
    .trig_out (trig_out),
    .meas     (mif)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trig(input logic [2:0] exp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (trig_out === exp) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Returns just after the edge that entered WAIT_RISE on channel c
  task automatic wait_rise_entry(input int c, output bit ok);
    bit ok1, ok2;
    logic [2:0] oh;
    oh = 3'b000;
    oh[c] = 1'b1;
    wait_trig(oh, ok1);
    wait_trig(3'b000, ok2);
    ok = ok1 & ok2;
  endtask

  task automatic wait_mv(output int lat);
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      tick(1);
      if (mif.meas_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic echo_pulse(input int c, input int width, output int lat);
    echo_in[c] = 1'b1;
    tick(width);
    echo_in[c] = 1'b0;
    wait_mv(lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena   = 1'b1;
    tick(3);
    checks++; if (trig_out !== 3'b000) begin errors++; $display("FAIL reset_trig: got %b want 000", trig_out); end
    checks++; if (mif.near !== 3'b000) begin errors++; $display("FAIL reset_near: got %b want 000", mif.near); end
    checks++; if (mif.meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mif.meas_valid); end
    checks++; if (mif.meas_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", mif.meas_chan); end
  endtask

  task automatic test_basic_ch0;
    bit ok;
    int n, lat;
    rst_n = 1'b1;
    wait_trig(3'b001, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_trig_start: trig_out never 001"); end
    n = 0;
    while (trig_out === 3'b001 && n < 20) begin
      n++;
      tick(1);
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_trig_width: got %0d want 4", n); end
    checks++; if (trig_out !== 3'b000) begin errors++; $display("FAIL basic_trig_end: got %b want 000", trig_out); end
    echo_pulse(0, 30, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
    checks++; if (mif.meas_chan !== 2'd0) begin errors++; $display("FAIL basic_chan: got %0d want 0", mif.meas_chan); end
    checks++; if (mif.near !== 3'b001) begin errors++; $display("FAIL basic_near: got %b want 001", mif.near); end
    tick(1);
    checks++; if (mif.meas_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_len: got %b want 0", mif.meas_valid); end
  endtask

  task automatic test_near_boundary;
    bit ok;
    int lat;
    wait_rise_entry(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bound50_trig: ch1 trigger not seen"); end
    echo_pulse(1, 50, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bound50_latency: got %0d want 3", lat); end
    checks++; if (mif.meas_chan !== 2'd1) begin errors++; $display("FAIL bound50_chan: got %0d want 1", mif.meas_chan); end
    checks++; if (mif.near !== 3'b001) begin errors++; $display("FAIL bound50_near: got %b want 001", mif.near); end
  endtask

  task automatic test_timeout_wrap;
    bit ok;
    int lat;
    wait_rise_entry(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_trig: ch2 trigger not seen"); end
    wait_mv(lat);
    checks++; if (lat !== 200) begin errors++; $display("FAIL timeout_latency: got %0d want 200", lat); end
    checks++; if (mif.meas_chan !== 2'd2) begin errors++; $display("FAIL timeout_chan: got %0d want 2", mif.meas_chan); end
    checks++; if (mif.near !== 3'b001) begin errors++; $display("FAIL timeout_near: got %b want 001", mif.near); end
    wait_trig(3'b001, ok);
    checks++; if (!ok || trig_out !== 3'b001) begin errors++; $display("FAIL wrap_trig: got %b want 001", trig_out); end
  endtask

  task automatic test_patterns;
    bit ok;
    int lat;
    wait_rise_entry(0, ok);
    echo_pulse(0, 60, lat);
    checks++; if (!ok || mif.near !== 3'b000) begin errors++; $display("FAIL far60_near: got %b want 000", mif.near); end
    wait_rise_entry(1, ok);
    echo_pulse(1, 49, lat);
    checks++; if (!ok || mif.near !== 3'b010) begin errors++; $display("FAIL bound49_near: got %b want 010", mif.near); end
    wait_rise_entry(2, ok);
    echo_pulse(2, 1, lat);
    checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL one_cycle_latency: got %0d want 3", lat); end
    checks++; if (mif.near !== 3'b110) begin errors++; $display("FAIL one_cycle_near: got %b want 110", mif.near); end
  endtask

  task automatic test_ena_drop;
    bit ok, seen;
    wait_rise_entry(0, ok);
    echo_in[0] = 1'b1;
    tick(10);
    ena = 1'b0;
    tick(1);
    checks++; if (!ok || trig_out !== 3'b000) begin errors++; $display("FAIL ena_trig: got %b want 000", trig_out); end
    checks++; if (mif.near !== 3'b000) begin errors++; $display("FAIL ena_near: got %b want 000", mif.near); end
    echo_in[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (mif.meas_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ena_abort: meas_valid got 1 want 0"); end
    ena = 1'b1;
    tick(1);
    checks++; if (trig_out !== 3'b001) begin errors++; $display("FAIL ena_restart: got %b want 001", trig_out); end
  endtask

  task automatic test_stuck_high;
    bit ok;
    int lat;
    rst_n   = 1'b0;
    echo_in = 3'b001;
    tick(2);
    rst_n = 1'b1;
    wait_rise_entry(0, ok);
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      echo_in[1] = ((i % 8) < 3);
      tick(1);
      if (mif.meas_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    echo_in = 3'b000;
    checks++; if (!ok || lat !== 200) begin errors++; $display("FAIL stuck_latency: got %0d want 200", lat); end
    checks++; if (mif.meas_chan !== 2'd0) begin errors++; $display("FAIL stuck_chan: got %0d want 0", mif.meas_chan); end
    checks++; if (mif.near !== 3'b000) begin errors++; $display("FAIL stuck_near: got %b want 000", mif.near); end
  endtask

  task automatic test_reset_in_trig;
    bit ok;
    wait_trig(3'b010, ok);
    tick(1);
    checks++; if (!ok || trig_out !== 3'b010) begin errors++; $display("FAIL rst_trig_pre: got %b want 010", trig_out); end
    rst_n = 1'b0;
    tick(1);
    checks++; if (trig_out !== 3'b000) begin errors++; $display("FAIL rst_trig_drop: got %b want 000", trig_out); end
    rst_n = 1'b1;
    tick(1);
    checks++; if (trig_out !== 3'b001) begin errors++; $display("FAIL rst_trig_resume: got %b want 001", trig_out); end
  endtask

  initial begin
    test_reset();
    test_basic_ch0();
    test_near_boundary();
    test_timeout_wrap();
    test_patterns();
    test_ena_drop();
    test_stuck_high();
    test_reset_in_trig();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
